cp0_irq_unit: RTL

//  Parametrised coprocessor-0 for the single-cycle CPU: Status/Cause/EPC with vectored exception

---
 rtl/cp0_pkg.sv | 42 ++++
 rtl/cp0_timer.sv | 34 +++
 rtl/cp0_irq_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, Status/Cause field positions, ExcCodes and write-priority select.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int TIMER_IP_BIT = 7;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TRAP    = 5'd13;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_EXCEPTION,
        WR_ERET,
        WR_MTC0
    } cp0_wr_sel_e;

    // Only one source may update CP0 state per cycle; the lower-priority ones are dropped.
    function automatic cp0_wr_sel_e wr_select(input logic exception, input logic eret, input logic mtc0);
        if (exception)
            return WR_EXCEPTION;
        else if (eret)
            return WR_ERET;
        else if (mtc0)
            return WR_MTC0;
        else
            return WR_NONE;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky match flag; only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              timer_pend
);

    // Writing Compare acknowledges the pending tick, even if the old match would have set it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            compare    <= '1;
            timer_pend <= 1'b0;
        end else begin
            count <= (wr_en && wr_addr == REG_COUNT) ? wdata : count + 1'b1;
            if (wr_en && wr_addr == REG_COMPARE) begin
                compare    <= wdata;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_irq_unit.sv
// Coprocessor 0: Status/Cause/EPC, vectored exception entry and maskable interrupts (DATA_W >= 16).
// Define CP0_TIMER_EN to add the Count/Compare timer on IP[7].
module cp0_irq_unit
    import cp0_pkg::*;
#(
    parameter int                NUM_IRQ    = 6,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 'h0000_4180
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         rd_addr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DATA_W-1:0]  pc,
    input  logic               exception,
    input  logic [4:0]         exc_code,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [DATA_W-1:0]  rdata,
    output logic [DATA_W-1:0]  status,
    output logic [DATA_W-1:0]  exc_addr,
    output logic               exc_redirect,
    output logic               int_req
);

    cp0_wr_sel_e        wr_sel;
    logic               ie;
    logic               exl;
    logic [7:0]         im;
    logic [4:0]         exc_code_q;
    logic [DATA_W-1:0]  epc;
    logic [NUM_IRQ-1:0] irq_q;
    logic [7:0]         ip_full;
    logic [DATA_W-1:0]  cause;

`ifdef CP0_TIMER_EN
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic              timer_pend;

    cp0_timer #(.DATA_W(DATA_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_sel == WR_MTC0),
        .wr_addr    (rd_addr),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );
`endif

    assign wr_sel = wr_select(exception, eret, mtc0);

    // A nested exception (EXL already set) must keep the EPC of the first one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie         <= 1'b0;
            exl        <= 1'b0;
            im         <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            irq_q      <= '0;
        end else begin
            irq_q <= irq;
            case (wr_sel)
                WR_EXCEPTION: begin
                    exc_code_q <= exc_code;
                    exl        <= 1'b1;
                    if (!exl)
                        epc <= pc;
                end
                WR_ERET: exl <= 1'b0;
                WR_MTC0: begin
                    case (rd_addr)
                        REG_STATUS: begin
                            ie  <= wdata[STATUS_IE];
                            exl <= wdata[STATUS_EXL];
                            im  <= wdata[STATUS_IM_HI:STATUS_IM_LO];
                        end
                        REG_CAUSE: exc_code_q <= wdata[CAUSE_EXC_HI:CAUSE_EXC_LO];
                        REG_EPC:   epc <= wdata;
                        default:   ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ip_full              = '0;
        ip_full[NUM_IRQ-1:0] = irq_q;
`ifdef CP0_TIMER_EN
        ip_full[TIMER_IP_BIT] = ip_full[TIMER_IP_BIT] | timer_pend;
`endif
    end

    assign status = {{(DATA_W-16){1'b0}}, im, 6'b0, exl, ie};
    assign cause  = {{(DATA_W-16){1'b0}}, ip_full, 1'b0, exc_code_q, 2'b0};

    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (rd_addr)
                REG_STATUS:  rdata = status;
                REG_CAUSE:   rdata = cause;
                REG_EPC:     rdata = epc;
`ifdef CP0_TIMER_EN
                REG_COUNT:   rdata = count;
                REG_COMPARE: rdata = compare;
`endif
                default:     rdata = '0;
            endcase
        end
    end

    assign int_req      = ie & ~exl & (|(ip_full & im));
    assign exc_redirect = exception | eret;
    assign exc_addr     = (wr_sel == WR_ERET) ? epc : EXC_VECTOR;

endmodule
